// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that time-shares one BCD conversion engine between N_REQ requesters.
// Optional RUN-cycle watchdog with an ABORT state is enabled by defining BCD_ARB_TIMEOUT_EN.
module bcd_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int W       = 16,
  parameter int TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       res_data,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               err,
  output logic               eng_ce,
  output logic [W-1:0]       eng_in,
  input  logic               eng_done,
  input  logic [W-1:0]       eng_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
`ifdef BCD_ARB_TIMEOUT_EN
  localparam logic [1:0] ST_ABORT = 2'd3;
  localparam int         CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_run_cnt;
`endif

  logic [1:0]      r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_grant_id;
  logic [W-1:0]    r_eng_in;
  logic [W-1:0]    r_res_data;

  logic            w_win_found;
  logic [ID_W-1:0] w_win_id;
  logic [W-1:0]    w_win_data;
  logic [ID_W-1:0] w_ptr_next;
  logic            w_ack_phase;

  // Search starts at r_ptr and wraps; iterating downward lets the lowest
  // offset from the pointer overwrite any later candidate.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
    w_win_found = 1'b0;
    w_win_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(r_ptr) + i) % N_REQ]) begin
        w_win_found = 1'b1;
        w_win_id    = ID_W'((int'(r_ptr) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == w_win_id) begin
        w_win_data = req_data[i*W +: W];
      end
    end
  end

  assign w_ptr_next = (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

`ifdef BCD_ARB_TIMEOUT_EN
  assign w_ack_phase = (r_state == ST_DONE) || (r_state == ST_ABORT);
  assign err         = (r_state == ST_ABORT);
`else
  assign w_ack_phase = (r_state == ST_DONE);
  assign err         = 1'b0;
`endif

  always_comb begin
    ack = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = w_ack_phase && (ID_W'(i) == r_grant_id);
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign eng_ce   = (r_state == ST_RUN);
  assign eng_in   = r_eng_in;
  assign res_data = r_res_data;
  assign grant_id = r_grant_id;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_eng_in   <= '0;
      r_res_data <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
      r_run_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_found) begin
            r_grant_id <= w_win_id;
            r_eng_in   <= w_win_data;
            r_state    <= ST_RUN;
`ifdef BCD_ARB_TIMEOUT_EN
            r_run_cnt  <= '0;
`endif
          end
        end
        ST_RUN: begin
          // A completion strobe in the limit cycle still counts as success.
          if (eng_done) begin
            r_res_data <= eng_out;
            r_state    <= ST_DONE;
          end
`ifdef BCD_ARB_TIMEOUT_EN
          else if (r_run_cnt == RUN_LIMIT) begin
            r_res_data <= '1;
            r_state    <= ST_ABORT;
          end else begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          r_ptr   <= w_ptr_next;
          r_state <= ST_IDLE;
        end
`ifdef BCD_ARB_TIMEOUT_EN
        ST_ABORT: begin
          r_ptr   <= w_ptr_next;
          r_state <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: directed requests, a behavioural engine, and a
// monitor that pops expected responses on every ack. Timeout cases need BCD_ARB_TIMEOUT_EN.
module tb_bcd_conv_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int W     = 16;
`ifdef BCD_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 63;
`endif

  typedef struct {
    int          id;
    logic [15:0] op;
    logic [15:0] res;
    logic        err;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [W-1:0]       res_data;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               err;
  logic               eng_ce;
  logic [W-1:0]       eng_in;
  logic               eng_done;
  logic [W-1:0]       eng_out;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ack_seen = 0;
  exp_t sb[$];

  logic [N_REQ-1:0] keep_mask = '0;
  int   eng_lat   = 3;
  logic eng_hang  = 1'b0;
  logic eng_stray = 1'b0;
  int   run_cnt   = 0;

  bcd_conv_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .W(W), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .res_data(res_data), .grant_id(grant_id), .busy(busy), .err(err),
    .eng_ce(eng_ce), .eng_in(eng_in), .eng_done(eng_done), .eng_out(eng_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input logic [15:0] b);
    logic [19:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      for (int d = 0; d < 5; d++) begin
        if (r[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
      end
      r = {r[18:0], b[i]};
    end
    return r[15:0];
  endfunction

  task automatic expect_txn(input int id, input logic [15:0] op, input logic [15:0] res,
                            input logic e);
    exp_t x;
    x.id = id; x.op = op; x.res = res; x.err = e;
    sb.push_back(x);
  endtask

  task automatic wait_acks(input int n, input int budget);
    int target;
    int c;
    target = ack_seen + n;
    c = 0;
    while (ack_seen < target && c < budget) begin
      @(negedge clk); #2;
      c++;
    end
    if (ack_seen < target) check("ack_wait_timeout", ack_seen, target);
  endtask

  task automatic wait_ce(input int budget);
    int c;
    c = 0;
    while (!eng_ce && c < budget) begin
      @(negedge clk); #2;
      c++;
    end
    check("eng_ce_seen", eng_ce, 1);
  endtask

  // Behavioural conversion engine: strobes eng_done eng_lat cycles into RUN.
  initial begin
    eng_done = 1'b0;
    eng_out  = '0;
    forever begin
      @(posedge clk); #1;
      run_cnt = eng_ce ? run_cnt + 1 : 0;
      if (eng_stray) begin
        eng_done = 1'b1;
      end else if (eng_ce && !eng_hang && run_cnt == eng_lat) begin
        eng_done = 1'b1;
        eng_out  = to_bcd(eng_in);
      end else begin
        eng_done = 1'b0;
      end
    end
  end

  // Monitor: every ack cycle consumes one scoreboard entry.
  initial begin
    exp_t x;
    logic done_prev;
    logic op_bad;
    done_prev = 1'b0;
    op_bad    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_prev = 1'b0;
        op_bad    = 1'b0;
      end else begin
        if (done_prev) check("ack_latency", (ack != 0), 1);
        done_prev = eng_ce && eng_done;
        if (eng_ce && sb.size() > 0 && eng_in !== sb[0].op) op_bad = 1'b1;
        if (ack != 0 || err) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: ack=%b err=%b res=0x%0h, none expected", ack, err, res_data);
          end else begin
            x = sb.pop_front();
            check("ack", ack, 32'(1) << x.id);
            check("res_data", res_data, x.res);
            check("grant_id", grant_id, x.id);
            check("err", err, x.err);
            check("eng_in_stable", op_bad, 0);
          end
          op_bad = 1'b0;
          ack_seen++;
          req = req & ~(ack & ~keep_mask);
        end
      end
    end
  end

  initial begin
    int run_cycles;
    int tgt;
    rst      = 1'b1;
    req      = '0;
    req_data = {16'h0063, 16'h270F, 16'h04D2, 16'h00FF};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_res_data", res_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_eng_ce", eng_ce, 0);
    check("rst_eng_in", eng_in, 0);
    #2 rst = 1'b0;

    // Round-robin with all four held: 0,1,2,3 then 0
    keep_mask = 4'b1111;
    expect_txn(0, 16'h00FF, 16'h0255, 1'b0);
    expect_txn(1, 16'h04D2, 16'h1234, 1'b0);
    expect_txn(2, 16'h270F, 16'h9999, 1'b0);
    expect_txn(3, 16'h0063, 16'h0099, 1'b0);
    expect_txn(0, 16'h00FF, 16'h0255, 1'b0);
    req = 4'b1111;
    wait_acks(4, 200);
    req       = 4'b0001;
    keep_mask = 4'b0000;
    wait_acks(1, 50);

    // Pointer wrap: grant 3, then 1001 -> 0, then 1001 -> 3, then 0
    expect_txn(3, 16'h0063, 16'h0099, 1'b0);
    req = 4'b1000;
    wait_acks(1, 50);
    keep_mask = 4'b0001;
    expect_txn(0, 16'h00FF, 16'h0255, 1'b0);
    expect_txn(3, 16'h0063, 16'h0099, 1'b0);
    expect_txn(0, 16'h00FF, 16'h0255, 1'b0);
    req = 4'b1001;
    wait_acks(2, 100);
    keep_mask = 4'b0000;
    wait_acks(1, 50);

    // Single request with engine latency 3
    eng_lat = 3;
    expect_txn(0, 16'h00FF, 16'h0255, 1'b0);
    req = 4'b0001;
    wait_ce(20);
    check("single_eng_in", eng_in, 16'h00FF);
    check("single_busy", busy, 1);
    wait_acks(1, 50);
    repeat (3) @(negedge clk);
    check("hold_res_data", res_data, 16'h0255);
    check("idle_busy", busy, 0);

    // Stray completion strobe while idle must be ignored
    #2 eng_stray = 1'b1;
    repeat (6) @(negedge clk);
    check("stray_busy", busy, 0);
    #2 eng_stray = 1'b0;
    repeat (2) @(negedge clk);

    // Request and operand dropped during RUN: latched operand still converted and acked
    eng_lat = 4;
    expect_txn(2, 16'h270F, 16'h9999, 1'b0);
    #2 req = 4'b0100;
    wait_ce(20);
    req = 4'b0000;
    req_data[2*W +: W] = 16'h1111;
    wait_acks(1, 50);
    req_data[2*W +: W] = 16'h270F;

    // Reset in the middle of RUN discards the conversion
    eng_lat = 6;
    req = 4'b0010;
    wait_ce(20);
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_eng_ce", eng_ce, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ack", ack, 0);
    check("midrst_res_data", res_data, 0);
    check("midrst_grant_id", grant_id, 0);
    #2;
    req = 4'b0000;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    expect_txn(1, 16'h04D2, 16'h1234, 1'b0);
    req = 4'b0010;
    wait_acks(1, 50);

`ifdef BCD_ARB_TIMEOUT_EN
    // Engine never completes: abort after TIMEOUT RUN cycles
    eng_hang = 1'b1;
    expect_txn(0, 16'h00FF, 16'hFFFF, 1'b1);
    req = 4'b0001;
    run_cycles = 0;
    tgt = ack_seen + 1;
    for (int c = 0; c < 100 && ack_seen < tgt; c++) begin
      @(negedge clk); #2;
      if (eng_ce) run_cycles++;
    end
    check("abort_ack_seen", (ack_seen >= tgt), 1);
    check("abort_run_cycles", run_cycles, TB_TIMEOUT);
    eng_hang = 1'b0;
    repeat (2) @(negedge clk);

    // Completion on the limit cycle wins over the timeout
    #2 eng_lat = TB_TIMEOUT;
    expect_txn(0, 16'h00FF, 16'h0255, 1'b0);
    req = 4'b0001;
    wait_acks(1, 50);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
